decomp_bit_aligner_ctrl: RTL and testbench
==========================================

// Module: decomp_bit_aligner_ctrl
// PURPOSE
//  Sequencer for the word-decompression front end. Keeps a 128-bit MSB-aligned buffer of compressed
//  bitstream. Refills it from the 32-bit input stream. Presents a 68-bit window (two worst-case
//  34-bit codewords) to the code decoder. Each accepted cycle it advances by the lengths that
//  length_generator returns (one or two words). Tracks per-block bit budget and signals done.
// PARAMETERS
//  IN_W    32   input stream word width (bits)
//  BUF_W   128  alignment buffer width (bits); must be >= WIN_W + IN_W
//  WIN_W   68   output window width = 2 x max codeword length (34)
//  LENGTH  6    width of each length_generator length input
//  BLK_W   16   width of block bit-count
// PORTS
//  i_clk          in   1        clock
//  i_reset        in   1        asynchronous, active-high reset
//  i_start        in   1        start block; sampled only in IDLE
//  i_block_bits   in   BLK_W    compressed bits in block (>0), latched on i_start
//  i_data         in   IN_W     compressed stream word, MSB first
//  i_valid        in   1        i_data valid
//  o_ready        out  1        controller accepts i_data this cycle
//  o_window       out  WIN_W    buf[BUF_W-1 -: WIN_W], zero below level
//  o_win_valid    out  1        window holds enough bits for decode
//  i_win_ready    in   1        decoder consumes window this cycle
//  i_two_words    in   1        consume both words (else word 1 only)
//  i_length1      in   LENGTH   bit length of word 1 (from length_generator)
//  i_length2      in   LENGTH   bit length of word 2 (from length_generator)
//  o_level        out  8        valid bits currently buffered (0..BUF_W)
//  o_done         out  1        one-cycle pulse: block fully consumed
//  o_err          out  1        sticky: consume length exceeded buffered bits
// BEHAVIOUR
//  Reset: state=IDLE; buffer=0. o_level=0, o_ready=0, o_win_valid=0, o_done=0, o_err=0, o_window=0.
//  FSM states:
//   IDLE: wait for i_start. Latch rem_in=i_block_bits and rem_out=i_block_bits. Clear buffer, go RUN.
//   RUN : refill and consume as below. When rem_out reaches 0, go DONE.
//   DONE: o_done=1 for exactly this cycle; buffer and level cleared; next state IDLE.
//  Refill: o_ready = RUN && rem_in>0 && level <= BUF_W-IN_W (combinational from registers).
//   On i_valid&&o_ready, the word is written at bit offset (level - consumed_this_cycle).
//   level += IN_W; rem_in -= min(IN_W, rem_in). Trailing pad bits beyond rem_out are never consumed.
//  Window valid: o_win_valid = RUN && (level >= WIN_W || (rem_in==0 && level>0 && rem_out>0)).
//  Consume: happens when o_win_valid && i_win_ready.
//   adv = i_length1 + (i_two_words ? i_length2 : 0), computed in 7 bits.
//   If adv > level or adv > rem_out: no shift, o_err set (sticky until reset), level unchanged.
//   Otherwise, next cycle: buffer <<= adv, level -= adv, rem_out -= adv.
//  Simultaneous refill and consume in one cycle: shift first, then insert the word at the new level.
//   Next level = level - adv + IN_W.
//  adv=0 (both lengths 0) is legal; the window is re-presented unchanged.
//  Latency: a consume is visible on o_window/o_level 1 cycle later. Refill is 1 cycle later.
//   First o_win_valid is 3 cycles after the first accepted word (3 words give 96 >= 68 bits),
//   given back-to-back i_valid.
//  i_start outside IDLE is ignored. Reset mid-block: immediate return to IDLE with all state cleared.
//  Arithmetic: level 8 bits unsigned; rem_in/rem_out BLK_W bits, saturating at 0.
// STRUCTURE
//  Shared package decomp_pkg: IN_W, WIN_W, MAX_CW_LEN=34, and the ctrl_state_e enum {IDLE,RUN,DONE}.
//  The code/length enums already used by length_generator also live there.
//  One sub-module: decomp_barrel_shifter (BUF_W-bit left shift by 0..WIN_W, combinational).
//  FSM, counters and refill insert stay in this module.
// TESTING
//  1 Reset: assert i_reset mid-RUN with level=96 -> same cycle o_level=0, o_ready=0, o_win_valid=0;
//    state IDLE after release.
//  2 Fill: i_start, i_block_bits=200, continuous i_valid -> o_ready high for words 1-3.
//    o_win_valid rises with level=96. o_ready stays high at 96, drops at level 128.
//  3 Single consume: code 00 (len1=2), i_two_words=0 -> o_level 128->126.
//    o_window is shifted by 2 bits.
//  4 Dual consume with refill: len1=34 (xxxx), len2=24 (mmxx), with i_valid in the same cycle.
//    Result: level 96->96-58+32=70; the inserted word sits at bit offset 38.
//  5 Block end: i_block_bits=40, feed 2 words.
//    Consume 34+6: o_win_valid is held with level 64 < 68 because rem_in=0.
//    After the consume, o_done pulses for 1 cycle, then IDLE with level 0.
//  6 Error: level=20, len1=34 requested -> o_err=1 (sticky), o_level stays 20, no shift.

Source files
------------

// File: rtl/decomp_pkg.sv
// Shared decompression-path constants, controller state and codeword types.
package decomp_pkg;
  localparam int unsigned IN_W       = 32;
  localparam int unsigned BUF_W      = 128;
  localparam int unsigned MAX_CW_LEN = 34;
  localparam int unsigned WIN_W      = 2 * MAX_CW_LEN;
  localparam int unsigned LENGTH     = 6;
  localparam int unsigned BLK_W      = 16;
  localparam int unsigned LVL_W      = 8;
  localparam int unsigned ADV_W      = 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_state_e;

  typedef enum logic [2:0] {
    CW_ZZZZ, CW_XXXX, CW_MMMM, CW_MMXX, CW_ZZZX, CW_MMMX
  } cw_code_e;

  // Encoded length (prefix + payload) of each codeword class.
  function automatic logic [LENGTH-1:0] cw_len(cw_code_e code);
    case (code)
      CW_ZZZZ: return LENGTH'(2);
      CW_XXXX: return LENGTH'(34);
      CW_MMMM: return LENGTH'(6);
      CW_MMXX: return LENGTH'(24);
      CW_ZZZX: return LENGTH'(12);
      CW_MMMX: return LENGTH'(16);
      default: return LENGTH'(MAX_CW_LEN);
    endcase
  endfunction
endpackage

// File: rtl/decomp_barrel_shifter.sv
// Logarithmic left shifter for the alignment buffer; zeros fill from the LSB side.
module decomp_barrel_shifter
  import decomp_pkg::*;
(
  input  logic [BUF_W-1:0] din,
  input  logic [ADV_W-1:0] shamt,
  output logic [BUF_W-1:0] dout
);

  always_comb begin
    dout = din;
    for (int unsigned s = 0; s < ADV_W; s++) begin
      if (shamt[s]) dout = dout << (1 << s);
    end
  end

endmodule

// File: rtl/decomp_bit_aligner_ctrl.sv
// Bit aligner for the decompression front end: refills an MSB-aligned buffer from the
// input stream and advances it by decoded codeword lengths while tracking the block budget.
module decomp_bit_aligner_ctrl
  import decomp_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BLK_W-1:0]  i_block_bits,
  input  logic [IN_W-1:0]   i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [WIN_W-1:0]  o_window,
  output logic              o_win_valid,
  input  logic              i_win_ready,
  input  logic              i_two_words,
  input  logic [LENGTH-1:0] i_length1,
  input  logic [LENGTH-1:0] i_length2,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_done,
  output logic              o_err
);

  ctrl_state_e      state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [BLK_W-1:0] rem_in_q, rem_in_d, rem_out_q, rem_out_d;
  logic             err_q, err_d, done_q, done_d;

  logic [ADV_W-1:0] adv;
  logic             consume, adv_bad, shift_ok, refill;
  logic [ADV_W-1:0] shamt;
  logic [BUF_W-1:0] shifted, word_msb, inserted;
  logic [LVL_W-1:0] lvl_shift;

  assign o_ready = (state_q == RUN) && (rem_in_q != '0)
                && (level_q <= LVL_W'(BUF_W - IN_W));
  assign o_win_valid = (state_q == RUN)
                    && ((level_q >= LVL_W'(WIN_W))
                     || ((rem_in_q == '0) && (level_q != '0) && (rem_out_q != '0)));

  assign o_window = buf_q[BUF_W-1 -: WIN_W];
  assign o_level  = level_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

  // Advance request and its legality against buffered bits and remaining budget.
  assign adv      = ADV_W'(i_length1) + (i_two_words ? ADV_W'(i_length2) : ADV_W'(0));
  assign consume  = o_win_valid && i_win_ready;
  assign adv_bad  = (LVL_W'(adv) > level_q) || (BLK_W'(adv) > rem_out_q);
  assign shift_ok = consume && !adv_bad;
  assign shamt    = shift_ok ? adv : ADV_W'(0);
  assign refill   = i_valid && o_ready;

  decomp_barrel_shifter u_shifter (
    .din   (buf_q),
    .shamt (shamt),
    .dout  (shifted)
  );

  // New word lands directly behind the bits that survive this cycle's shift.
  assign lvl_shift = level_q - LVL_W'(shamt);
  assign word_msb  = {i_data, {(BUF_W-IN_W){1'b0}}};
  assign inserted  = word_msb >> lvl_shift;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      level_q   <= '0;
      rem_in_q  <= '0;
      rem_out_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      level_q   <= level_d;
      rem_in_q  <= rem_in_d;
      rem_out_q <= rem_out_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    level_d   = level_q;
    rem_in_d  = rem_in_q;
    rem_out_d = rem_out_q;
    err_d     = err_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          rem_in_d  = i_block_bits;
          rem_out_d = i_block_bits;
          buf_d     = '0;
          level_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        buf_d     = shifted | (refill ? inserted : '0);
        level_d   = lvl_shift + (refill ? LVL_W'(IN_W) : LVL_W'(0));
        rem_out_d = rem_out_q - BLK_W'(shamt);
        if (refill) begin
          rem_in_d = (rem_in_q > BLK_W'(IN_W)) ? (rem_in_q - BLK_W'(IN_W)) : '0;
        end
        if (consume && adv_bad) err_d = 1'b1;
        if (rem_out_d == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        buf_d     = '0;
        level_d   = '0;
        rem_in_d  = '0;
        rem_out_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decomp_bit_aligner_ctrl.sv
// Randomized bench for decomp_bit_aligner_ctrl against a bit-queue reference model.
module tb_decomp_bit_aligner_ctrl;
  import decomp_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [BLK_W-1:0]  i_block_bits;
  logic [IN_W-1:0]   i_data;
  logic              i_valid;
  logic              o_ready;
  logic [WIN_W-1:0]  o_window;
  logic              o_win_valid;
  logic              i_win_ready;
  logic              i_two_words;
  logic [LENGTH-1:0] i_length1;
  logic [LENGTH-1:0] i_length2;
  logic [LVL_W-1:0]  o_level;
  logic              o_done;
  logic              o_err;

  always #5 clk = ~clk;

  decomp_bit_aligner_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (i_start),
    .i_block_bits (i_block_bits),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_window     (o_window),
    .o_win_valid  (o_win_valid),
    .i_win_ready  (i_win_ready),
    .i_two_words  (i_two_words),
    .i_length1    (i_length1),
    .i_length2    (i_length2),
    .o_level      (o_level),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: buffered stream as a queue of bits, oldest (MSB) first.
  bit mq[$];
  int m_state;              // 0 idle, 1 running, 2 done
  int m_rem_in, m_rem_out;
  bit m_err, m_done;

  function automatic bit m_ready();
    return (m_state == 1) && (m_rem_in > 0) && (mq.size() <= 96);
  endfunction

  function automatic bit m_wv();
    return (m_state == 1) && ((mq.size() >= 68) ||
           ((m_rem_in == 0) && (mq.size() > 0) && (m_rem_out > 0)));
  endfunction

  function automatic logic [67:0] m_window();
    logic [67:0] w = '0;
    for (int i = 0; i < 68 && i < mq.size(); i++) w[67-i] = mq[i];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_rem_in = 0; m_rem_out = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_step(input bit start, input int bb, input bit valid,
                            input logic [31:0] data, input bit wr, input bit two,
                            input int l1, input int l2);
    bit rdy, wv;
    int adv;
    rdy = m_ready();
    wv  = m_wv();
    adv = l1 + (two ? l2 : 0);
    m_done = 0;
    case (m_state)
      0: if (start) begin
        m_rem_in = bb; m_rem_out = bb; mq.delete(); m_state = 1;
      end
      1: begin
        if (wv && wr) begin
          if (adv > mq.size() || adv > m_rem_out) m_err = 1;
          else begin
            for (int i = 0; i < adv; i++) void'(mq.pop_front());
            m_rem_out -= adv;
          end
        end
        if (valid && rdy) begin
          for (int i = 31; i >= 0; i--) mq.push_back(data[i]);
          m_rem_in = (m_rem_in > 32) ? m_rem_in - 32 : 0;
        end
        if (m_rem_out == 0) begin m_state = 2; m_done = 1; end
      end
      default: begin mq.delete(); m_state = 0; end
    endcase
  endtask

  task automatic check_all();
    check("level",     128'(o_level),     128'(mq.size()));
    check("ready",     128'(o_ready),     128'(m_ready()));
    check("win_valid", 128'(o_win_valid), 128'(m_wv()));
    check("window",    128'(o_window),    128'(m_window()));
    check("done",      128'(o_done),      128'(m_done));
    check("err",       128'(o_err),       128'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model, and compare on the next falling edge.
  task automatic step(input bit start, input int bb, input bit valid,
                      input logic [31:0] data, input bit wr, input bit two,
                      input int l1, input int l2);
    i_start = start; i_block_bits = 16'(bb); i_valid = valid; i_data = data;
    i_win_ready = wr; i_two_words = two; i_length1 = 6'(l1); i_length2 = 6'(l2);
    model_step(start, bb, valid, data, wr, two, l1, l2);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    i_start = 0; i_block_bits = '0; i_valid = 0; i_data = '0;
    i_win_ready = 0; i_two_words = 0; i_length1 = '0; i_length2 = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  logic [WIN_W-1:0] w0;
  logic [31:0]      d;
  bit               valid, wr, two, st;
  int               l1, l2, cyc, mn;

  initial begin
    reset_dut();

    // Asynchronous reset while holding 96 buffered bits
    step(1, 200, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 3; w++) step(0, 0, 1, $urandom, 0, 0, 0, 0);
    check("t1_lvl96", 128'(o_level), 128'(96));
    #2 rst = 1'b1;
    idle_inputs();
    #1;
    check("t1_rst_level", 128'(o_level),     128'(0));
    check("t1_rst_ready", 128'(o_ready),     128'(0));
    check("t1_rst_wv",    128'(o_win_valid), 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_idle_ready", 128'(o_ready), 128'(0));

    // Fill to 128 bits
    step(1, 200, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < 4; w++) begin
      step(0, 0, 1, $urandom, 0, 0, 0, 0);
      if (w == 2) begin
        check("t2_wv96",    128'(o_win_valid), 128'(1));
        check("t2_ready96", 128'(o_ready),     128'(1));
      end
    end
    check("t2_lvl128",   128'(o_level), 128'(128));
    check("t2_ready128", 128'(o_ready), 128'(0));

    // Single 2-bit consume
    w0 = o_window;
    step(0, 0, 1, $urandom, 1, 0, 2, 0);
    check("t3_lvl126", 128'(o_level), 128'(126));
    check("t3_shift",  128'(o_window[WIN_W-1:2]), 128'(w0[WIN_W-3:0]));

    // Dual consume with simultaneous refill
    step(0, 0, 0, 0, 1, 0, 30, 0);
    check("t4_lvl96", 128'(o_level), 128'(96));
    d = $urandom;
    step(0, 0, 1, d, 1, 1, 34, 24);
    check("t4_lvl70",  128'(o_level), 128'(70));
    check("t4_insert", 128'(o_window[29:0]), 128'(d[31:2]));

    // Block end with short tail held valid by exhausted input budget
    reset_dut();
    step(1, 40, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, $urandom, 0, 0, 0, 0);
    step(0, 0, 1, $urandom, 0, 0, 0, 0);
    check("t5_lvl64",  128'(o_level),     128'(64));
    check("t5_wv",     128'(o_win_valid), 128'(1));
    check("t5_ready0", 128'(o_ready),     128'(0));
    step(0, 0, 0, 0, 1, 1, 34, 6);
    check("t5_done", 128'(o_done), 128'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_done_off", 128'(o_done),  128'(0));
    check("t5_lvl0",     128'(o_level), 128'(0));

    // Over-length consume sets sticky error without shifting
    step(1, 20, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, $urandom, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 12, 0);
    check("t6_lvl20", 128'(o_level), 128'(20));
    w0 = o_window;
    step(0, 0, 0, 0, 1, 0, 34, 0);
    check("t6_err",      128'(o_err),    128'(1));
    check("t6_lvl_hold", 128'(o_level),  128'(20));
    check("t6_noshift",  128'(o_window), 128'(w0));
    step(0, 0, 0, 0, 1, 0, 8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_err_sticky", 128'(o_err), 128'(1));
    reset_dut();
    check("t6_err_clr", 128'(o_err), 128'(0));

    // Random blocks
    for (int b = 0; b < 20; b++) begin
      step(1, $urandom_range(400, 1), 0, 0, 0, 0, 0, 0);
      cyc = 0;
      while (m_state != 0 && cyc < 3000) begin
        valid = ($urandom_range(9, 0) < 7);
        wr    = ($urandom_range(3, 0) != 0);
        two   = 1'($urandom_range(1, 0));
        st    = ($urandom_range(15, 0) == 0);
        l1    = $urandom_range(34, 0);
        l2    = $urandom_range(34, 0);
        if ($urandom_range(3, 0) == 0) begin
          mn = m_rem_out;
          if (mq.size() < mn) mn = mq.size();
          if (mn > 34) mn = 34;
          two = 0; l1 = mn;
        end
        step(st, $urandom_range(400, 1), valid, $urandom, wr, two, l1, l2);
        cyc++;
      end
      check("blk_timeout", 128'(cyc >= 3000), 128'(0));
      step(0, 0, 0, 0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
